// File: rtl/mccoy_pkg.sv
// Shared opcode encodings and helpers for the parametrised McCoy accumulator core.
package mccoy_pkg;

  localparam logic [2:0] OP_BEZ = 3'b000;
  localparam logic [2:0] OP_LI  = 3'b001;
  localparam logic [2:0] OP_JA  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_LR  = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SR  = 3'b110;
  localparam logic [2:0] OP_OUT = 3'b111;

  // Sign-extend the low 'w' bits of 'v' to 32 bits; callers truncate to their width.
  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] t;
    t = signed'(v << (32 - w));
    return 32'(t >>> (32 - w));
  endfunction

endpackage

// File: rtl/mccoy_regfile.sv
// General-purpose register file: one write port, one asynchronous read port.
module mccoy_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/mccoy_param_core.sv
// Single-cycle accumulator CPU executing one externally supplied instruction per clock.
module mccoy_param_core
  import mccoy_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned IMM_W  = 3,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IMM_W+2:0]  instr_i,
  input  logic              instr_valid_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic              carry_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o
);

  localparam int unsigned RegW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [2:0]             op;
  logic [IMM_W-1:0]       arg;
  logic [RegW-1:0]        ridx;
  logic [31:0]            imm32;
  logic [DATA_W-1:0]      rdata;
  logic [DATA_W:0]        sum, diff;
  logic [PC_W+DATA_W-1:0] acc_ext;
  logic                   rf_we;

  assign op      = instr_i[2:0];
  assign arg     = instr_i[IMM_W+2:3];
  assign ridx    = arg[RegW-1:0];
  assign imm32   = sext(32'(arg), IMM_W);
  assign sum     = {1'b0, acc_q} + {1'b0, rdata};
  // Top bit of the widened difference is the borrow, i.e. x[r] > acc unsigned.
  assign diff    = {1'b0, acc_q} - {1'b0, rdata};
  assign acc_ext = {{PC_W{1'b0}}, acc_q};

  mccoy_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (RegW)
  ) u_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (rf_we),
    .waddr_i (ridx),
    .wdata_i (acc_q),
    .raddr_i (ridx),
    .rdata_o (rdata)
  );

  always_comb begin
    pc_d        = pc_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    rf_we       = 1'b0;
    if (instr_valid_i) begin
      pc_d = pc_q + PC_W'(1);
      unique case (op)
        OP_BEZ: if (acc_q == '0) pc_d = pc_q + imm32[PC_W-1:0];
        OP_LI:  acc_d = imm32[DATA_W-1:0];
        OP_JA:  pc_d = acc_ext[PC_W-1:0];
        OP_ADD: {carry_d, acc_d} = sum;
        OP_LR:  acc_d = rdata;
        OP_SUB: {carry_d, acc_d} = diff;
        OP_SR:  rf_we = 1'b1;
        OP_OUT: begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc_o        = pc_q;
  assign acc_o       = acc_q;
  assign carry_o     = carry_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule
